bullet_hit_detector: RTL and testbench
======================================

// Module: bullet_hit_detector
// PURPOSE
//  Receiving end of a bullet object: samples the opponent's bullet each frame and decides whether it struck this player.
//  Returns the one-frame player_hit pulse the bullet uses to retire itself.
//  Tracks player health, post-hit invulnerability and death state for the sprite/score logic.
//  One instance per player, clocked by frame_clk next to that player's ball and the opponent's bullet.
// PARAMETERS
//  MAX_HEALTH     3   health after reset/respawn; HEALTH_W wide
//  HEALTH_W       3   width of health counter
//  INVULN_FRAMES  60  frames of hit immunity after a non-fatal hit (>=2)
//  BLINK_PERIOD   4   frames per blink half-period while invulnerable
//  UPGRADE_DMG    2   damage dealt by an upgraded bullet (normal = 1)
// PORTS
//  frame_clk  in   1         frame clock (one edge per video frame)
//  Reset      in   1         asynchronous, active-high
//  BulletX    in   10        opponent bullet centre X
//  BulletY    in   10        opponent bullet centre Y
//  BulletS    in   10        opponent bullet half-size
//  bullet_on  in   1         opponent bullet in flight
//  upgraded   in   1         opponent bullet is upgraded
//  BallX      in   10        this player centre X
//  BallY      in   10        this player centre Y
//  BallS      in   10        this player half-size
//  respawn    in   1         level: leave DEAD, restore health
//  player_hit out  1         one-frame hit pulse to opponent bullet
//  health     out  HEALTH_W  remaining health
//  invuln     out  1         in INVULN state
//  blink      out  1         sprite visibility gate (1 = draw)
//  dead       out  1         in DEAD state
// BEHAVIOUR
//  Reset, async, asserts immediately:
//   state=ALIVE, health=MAX_HEALTH, player_hit=0, invuln=0, blink=1, dead=0, counters=0.
//  Overlap (combinational), computed on 11-bit unsigned values so nothing wraps:
//   dx = |BulletX-BallX|, dy = |BulletY-BallY|, formed as larger minus smaller.
//   overlap = bullet_on & (dx < BulletS+BallS) & (dy < BulletS+BallS). Touching edges (equal) is not a hit.
//  dmg = upgraded ? UPGRADE_DMG : 1.
//  FSM, registered on frame_clk:
//   ALIVE:  overlap -> player_hit<=1 for exactly the next frame; health <= sat(health-dmg, floor 0).
//           If the new health is 0 -> DEAD, else -> INVULN with inv_cnt<=INVULN_FRAMES-1.
//   INVULN: overlap ignored, player_hit stays 0. inv_cnt decrements each frame; inv_cnt==0 -> ALIVE.
//           blink toggles each time blink_cnt reaches BLINK_PERIOD-1; blink forced to 1 on exit.
//   DEAD:   overlap ignored; health=0, dead=1, blink=0.
//           respawn=1 -> ALIVE, health=MAX_HEALTH, dead=0, blink=1.
//  player_hit is registered: high for the single frame after the overlap sample, never two frames in a row.
//   INVULN_FRAMES>=2 covers the frame the bullet needs to see player_hit and clear itself.
//  respawn is ignored in ALIVE and INVULN.
//  Overlap and respawn in the same DEAD frame: respawn wins. Overlap is not evaluated until the next frame in ALIVE.
//  Reset mid-INVULN or mid-DEAD: full return to the reset values; no pending hit survives.
//  Latency: overlap at edge N -> player_hit/health/state updated at edge N+1.
// STRUCTURE
//  game_pkg: hit_state_t enum {ALIVE, INVULN, DEAD}; SCREEN_W=640, SCREEN_H=480; COORD_W=10.
//  Sub-module box_overlap: pure combinational overlap test, reused later for barrier collision.
//   Inputs: two centres and two half-sizes. Output: overlap.
//  Top level holds the FSM, health, inv_cnt and blink_cnt.
// TESTING
//  1. Ball(320,240,S=10), bullet on at (330,240,S=4): player_hit=1 one frame later, health 3->2, invuln=1.
//  2. Bullet at (334,240,S=4) with ball S=10 (dx=14=sum): no hit. At (333,240): hit.
//  3. Bullet held overlapping for 10 frames after a hit: exactly one player_hit pulse, health stays 2.
//     blink toggles every 4 frames; ALIVE again after 60 frames.
//  4. health=1 with upgraded=1 overlap: health saturates to 0, dead=1, blink=0.
//     Further overlaps give no pulse. respawn=1 -> health=3, dead=0.
//  5. Reset asserted between edges mid-INVULN: outputs return to the reset values before the next frame_clk.
//  6. bullet_on=0 with coordinates coincident with the ball: no hit for 20 frames.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-level types and constants for the per-player hit logic.
package game_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned COORD_W  = 10;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } hit_state_t;

endpackage

// File: rtl/bullet_hit_detector_if.sv
// Bullet/ball geometry in, player hit status out.
interface bullet_hit_detector_if
    import game_pkg::*;
#(
    parameter int unsigned HEALTH_W = 3
);

    logic [COORD_W-1:0]  BulletX;
    logic [COORD_W-1:0]  BulletY;
    logic [COORD_W-1:0]  BulletS;
    logic                bullet_on;
    logic                upgraded;
    logic [COORD_W-1:0]  BallX;
    logic [COORD_W-1:0]  BallY;
    logic [COORD_W-1:0]  BallS;
    logic                respawn;
    logic                player_hit;
    logic [HEALTH_W-1:0] health;
    logic                invuln;
    logic                blink;
    logic                dead;

    modport master (
        output BulletX, BulletY, BulletS, bullet_on, upgraded,
        output BallX, BallY, BallS, respawn,
        input  player_hit, health, invuln, blink, dead
    );

    modport slave (
        input  BulletX, BulletY, BulletS, bullet_on, upgraded,
        input  BallX, BallY, BallS, respawn,
        output player_hit, health, invuln, blink, dead
    );

endinterface

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap test on centre/half-size boxes.
module box_overlap
    import game_pkg::*;
(
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] a_s,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [COORD_W-1:0] b_s,
    output logic               overlap
);

    // One extra bit so the half-size sum cannot wrap.
    localparam int unsigned EXT_W = COORD_W + 1;

    logic [EXT_W-1:0] dx;
    logic [EXT_W-1:0] dy;
    logic [EXT_W-1:0] reach;

    // Distances as larger minus smaller; touching edges do not count.
    always_comb begin
        dx      = (a_x >= b_x) ? EXT_W'(a_x) - EXT_W'(b_x) : EXT_W'(b_x) - EXT_W'(a_x);
        dy      = (a_y >= b_y) ? EXT_W'(a_y) - EXT_W'(b_y) : EXT_W'(b_y) - EXT_W'(a_y);
        reach   = EXT_W'(a_s) + EXT_W'(b_s);
        overlap = (dx < reach) && (dy < reach);
    end

endmodule

// File: rtl/bullet_hit_detector.sv
// Per-player hit detection, health, post-hit invulnerability and death.
module bullet_hit_detector
    import game_pkg::*;
#(
    parameter int unsigned MAX_HEALTH    = 3,
    parameter int unsigned HEALTH_W      = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned BLINK_PERIOD  = 4,
    parameter int unsigned UPGRADE_DMG   = 2
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    bullet_hit_detector_if.slave  bus
);

    localparam int unsigned INV_W = (INVULN_FRAMES > 2) ? $clog2(INVULN_FRAMES) : 1;
    localparam int unsigned BLK_W = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;

    localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] DMG_NORMAL  = HEALTH_W'(1);
    localparam logic [HEALTH_W-1:0] DMG_UPGRADE = HEALTH_W'(UPGRADE_DMG);
    localparam logic [INV_W-1:0]    INV_START   = INV_W'(INVULN_FRAMES - 1);
    localparam logic [BLK_W-1:0]    BLINK_LAST  = BLK_W'(BLINK_PERIOD - 1);

    hit_state_t          state,     state_n;
    logic [HEALTH_W-1:0] health_q,  health_n;
    logic [INV_W-1:0]    inv_cnt,   inv_cnt_n;
    logic [BLK_W-1:0]    blink_cnt, blink_cnt_n;
    logic                hit_q,     hit_n;
    logic                blink_q,   blink_n;
    logic                invuln_q,  invuln_n;
    logic                dead_q,    dead_n;
    logic                geom_hit_c;
    logic                overlap_c;
    logic [HEALTH_W-1:0] dmg_c;

    box_overlap u_box_overlap (
        .a_x     (bus.BulletX),
        .a_y     (bus.BulletY),
        .a_s     (bus.BulletS),
        .b_x     (bus.BallX),
        .b_y     (bus.BallY),
        .b_s     (bus.BallS),
        .overlap (geom_hit_c)
    );

    // Only a bullet in flight can hit; upgraded bullets hit harder.
    always_comb begin
        overlap_c = bus.bullet_on & geom_hit_c;
        dmg_c     = bus.upgraded ? DMG_UPGRADE : DMG_NORMAL;
    end

    // State, health, counters and registered outputs.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state     <= ALIVE;
            health_q  <= HEALTH_FULL;
            inv_cnt   <= '0;
            blink_cnt <= '0;
            hit_q     <= 1'b0;
            blink_q   <= 1'b1;
            invuln_q  <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state     <= state_n;
            health_q  <= health_n;
            inv_cnt   <= inv_cnt_n;
            blink_cnt <= blink_cnt_n;
            hit_q     <= hit_n;
            blink_q   <= blink_n;
            invuln_q  <= invuln_n;
            dead_q    <= dead_n;
        end
    end

    // Next-state: hit handling in ALIVE, immunity countdown, death/respawn.
    always_comb begin
        state_n     = state;
        health_n    = health_q;
        inv_cnt_n   = inv_cnt;
        blink_cnt_n = blink_cnt;
        hit_n       = 1'b0;
        blink_n     = blink_q;

        case (state)
            ALIVE: begin
                if (overlap_c) begin
                    hit_n    = 1'b1;
                    health_n = (health_q > dmg_c) ? health_q - dmg_c : '0;
                    if (health_n == '0) begin
                        state_n = DEAD;
                        blink_n = 1'b0;
                    end else begin
                        state_n     = INVULN;
                        inv_cnt_n   = INV_START;
                        blink_cnt_n = '0;
                        blink_n     = 1'b1;
                    end
                end
            end
            INVULN: begin
                if (inv_cnt == '0) begin
                    state_n     = ALIVE;
                    blink_cnt_n = '0;
                    blink_n     = 1'b1;
                end else begin
                    inv_cnt_n = inv_cnt - INV_W'(1);
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt_n = '0;
                        blink_n     = ~blink_q;
                    end else begin
                        blink_cnt_n = blink_cnt + BLK_W'(1);
                    end
                end
            end
            DEAD: begin
                health_n = '0;
                blink_n  = 1'b0;
                if (bus.respawn) begin
                    state_n  = ALIVE;
                    health_n = HEALTH_FULL;
                    blink_n  = 1'b1;
                end
            end
            default: begin
                state_n  = ALIVE;
                health_n = HEALTH_FULL;
                blink_n  = 1'b1;
            end
        endcase

        invuln_n = (state_n == INVULN);
        dead_n   = (state_n == DEAD);
    end

    assign bus.player_hit = hit_q;
    assign bus.health     = health_q;
    assign bus.invuln     = invuln_q;
    assign bus.blink      = blink_q;
    assign bus.dead       = dead_q;

endmodule

// File: tb/tb_bullet_hit_detector.sv
// Self-checking bench: directed scenarios plus random frames vs. a behavioural model.
module tb_bullet_hit_detector;
    import game_pkg::*;

    localparam int unsigned MAXH = 3;
    localparam int unsigned HW   = 3;
    localparam int unsigned INVF = 60;
    localparam int unsigned BP   = 4;
    localparam int unsigned UPD  = 2;

    logic frame_clk = 1'b0;
    logic Reset;

    always #5 frame_clk = ~frame_clk;

    bullet_hit_detector_if #(.HEALTH_W(HW)) bus ();

    bullet_hit_detector #(
        .MAX_HEALTH    (MAXH),
        .HEALTH_W      (HW),
        .INVULN_FRAMES (INVF),
        .BLINK_PERIOD  (BP),
        .UPGRADE_DMG   (UPD)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int pulses;

    // Model: mode 0=alive 1=immune 2=dead; m_e = frames spent immune so far.
    int m_mode, m_health, m_e, m_hit;

    task automatic check(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic bit model_overlap();
        int reach;
        reach = int'(bus.BulletS) + int'(bus.BallS);
        return bus.bullet_on
            && (absd(int'(bus.BulletX), int'(bus.BallX)) < reach)
            && (absd(int'(bus.BulletY), int'(bus.BallY)) < reach);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_health = MAXH; m_e = 0; m_hit = 0;
    endtask

    task automatic model_edge();
        int dmg;
        bit ov;
        ov    = model_overlap();
        dmg   = bus.upgraded ? UPD : 1;
        m_hit = 0;
        case (m_mode)
            0: if (ov) begin
                m_hit    = 1;
                m_health = (m_health > dmg) ? m_health - dmg : 0;
                if (m_health == 0) m_mode = 2;
                else begin m_mode = 1; m_e = 0; end
            end
            1: begin
                m_e++;
                if (m_e == INVF) m_mode = 0;
            end
            default: if (bus.respawn) begin
                m_mode = 0; m_health = MAXH;
            end
        endcase
    endtask

    function automatic int model_blink();
        if (m_mode == 2) return 0;
        if (m_mode == 1) return ((m_e / BP) % 2 == 0) ? 1 : 0;
        return 1;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".hit"},    int'(bus.player_hit), m_hit);
        check({tag, ".health"}, int'(bus.health),     m_health);
        check({tag, ".invuln"}, int'(bus.invuln),     (m_mode == 1) ? 1 : 0);
        check({tag, ".blink"},  int'(bus.blink),      model_blink());
        check({tag, ".dead"},   int'(bus.dead),       (m_mode == 2) ? 1 : 0);
    endtask

    task automatic frame(input string tag);
        @(posedge frame_clk);
        if (Reset) model_reset();
        else       model_edge();
        #1;
        if (bus.player_hit === 1'b1) pulses++;
        check_outputs(tag);
    endtask

    task automatic set_ball(input int x, input int y, input int s);
        bus.BallX = COORD_W'(x); bus.BallY = COORD_W'(y); bus.BallS = COORD_W'(s);
    endtask

    task automatic set_bullet(input int x, input int y, input int s, input bit on, input bit up);
        bus.BulletX = COORD_W'(x); bus.BulletY = COORD_W'(y); bus.BulletS = COORD_W'(s);
        bus.bullet_on = on; bus.upgraded = up;
    endtask

    initial begin
        Reset = 1'b1;
        bus.respawn = 1'b0;
        set_ball(0, 0, 0);
        set_bullet(0, 0, 0, 1'b0, 1'b0);
        #2;
        model_reset();
        check_outputs("reset");
        frame("reset_hold");
        Reset = 1'b0;

        // Basic hit: 3 -> 2, immune next frame.
        set_ball(320, 240, 10);
        set_bullet(330, 240, 4, 1'b1, 1'b0);
        frame("t1");
        check("t1_hit", int'(bus.player_hit), 1);
        check("t1_health", int'(bus.health), 2);
        check("t1_invuln", int'(bus.invuln), 1);

        // Bullet held inside the ball while immune: no further pulses.
        pulses = 0;
        for (int i = 0; i < 10; i++) frame("t3_hold");
        check("t3_pulses", pulses, 0);
        check("t3_health", int'(bus.health), 2);
        set_bullet(330, 240, 4, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) frame("t3_wait");
        check("t3_alive", int'(bus.invuln), 0);
        check("t3_blink", int'(bus.blink), 1);

        // Edge-touching is not a hit; one pixel closer is.
        set_bullet(334, 240, 4, 1'b1, 1'b0);
        frame("t2_touch");
        check("t2_touch_hit", int'(bus.player_hit), 0);
        set_bullet(333, 240, 4, 1'b1, 1'b0);
        frame("t2_in");
        check("t2_in_hit", int'(bus.player_hit), 1);
        check("t2_in_health", int'(bus.health), 1);
        set_bullet(333, 240, 4, 1'b0, 1'b0);
        for (int i = 0; i < 61; i++) frame("t2_wait");

        // Upgraded bullet at health 1 saturates to 0 and kills.
        set_bullet(325, 245, 4, 1'b1, 1'b1);
        frame("t4_kill");
        check("t4_health", int'(bus.health), 0);
        check("t4_dead", int'(bus.dead), 1);
        check("t4_blink", int'(bus.blink), 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) frame("t4_dead_hold");
        check("t4_pulses", pulses, 0);
        bus.respawn = 1'b1;
        frame("t4_respawn");
        check("t4_resp_health", int'(bus.health), 3);
        check("t4_resp_dead", int'(bus.dead), 0);
        check("t4_resp_hit", int'(bus.player_hit), 0);
        bus.respawn = 1'b0;
        set_bullet(325, 245, 4, 1'b1, 1'b0);
        frame("t4_rehit");

        // Asynchronous reset between edges while immune.
        set_bullet(325, 245, 4, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) frame("t5_pre");
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check_outputs("t5_async");
        #1 Reset = 1'b0;
        frame("t5_post");

        // Coincident but not in flight: never a hit.
        set_ball(100, 100, 8);
        set_bullet(100, 100, 8, 1'b0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 20; i++) frame("t6");
        check("t6_pulses", pulses, 0);

        // Random frames near the ball.
        for (int i = 0; i < 1500; i++) begin
            int bx, by;
            bx = int'($urandom_range(0, 1023));
            by = int'($urandom_range(0, 1023));
            set_ball(bx, by, int'($urandom_range(0, 20)));
            set_bullet((bx + int'($urandom_range(0, 60)) - 30) & 1023,
                       (by + int'($urandom_range(0, 60)) - 30) & 1023,
                       int'($urandom_range(0, 12)),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
            bus.respawn = ($urandom_range(0, 15) == 0);
            frame("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
